// File: rtl/msk_pkg.sv
// Shared definitions for the masked FIFO: clog2 helper, level/pointer width helpers and share-index macro.
// Optional feature macro used by the block: MSK_REFRESH_EN.
`ifndef MSK_PKG_SV
`define MSK_PKG_SV

`define MSK_SIDX(k, j, d) ((k) * (d) + (j))

package msk_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Width of an occupancy counter able to hold 0..depth.
    function automatic int lvl_w(input int depth);
        return clog2(depth + 1);
    endfunction

    // Pointer width, kept at least 1 bit so DEPTH=1 still has a legal vector.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? clog2(depth) : 1;
    endfunction

endpackage

`endif

// File: rtl/msk_fifo_entry.sv
// One FIFO entry holding count sharings of d shares each, with write-enable and async clear.
// With MSK_REFRESH_EN defined, an occupied entry that is not being written is re-randomised each edge.
module msk_fifo_entry
    import msk_pkg::*;
#(
    parameter int d     = 2,
    parameter int count = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [count*d-1:0]       i_wdata,
`ifdef MSK_REFRESH_EN
    input  logic                     i_ref_en,
    input  logic [count*(d-1)-1:0]   i_rnd,
`endif
    output logic [count*d-1:0]       o_q
);

    logic [count*d-1:0] r_q;

`ifdef MSK_REFRESH_EN
    logic [count*d-1:0] w_ref;

    // Each fresh random bit is applied to one share and to the last share, so the XOR of shares is kept.
    always_comb begin
        logic par;
        w_ref = r_q;
        for (int k = 0; k < count; k++) begin
            par = 1'b0;
            for (int j = 0; j < d - 1; j++) begin
                w_ref[`MSK_SIDX(k, j, d)] = r_q[`MSK_SIDX(k, j, d)] ^ i_rnd[k*(d-1)+j];
                par = par ^ i_rnd[k*(d-1)+j];
            end
            w_ref[`MSK_SIDX(k, d-1, d)] = r_q[`MSK_SIDX(k, d-1, d)] ^ par;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_q <= '0;
        else if (i_we)
            r_q <= i_wdata;
        else if (i_ref_en)
            r_q <= w_ref;
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_q <= '0;
        else if (i_we)
            r_q <= i_wdata;
    end
`endif

    assign o_q = r_q;

endmodule

// File: rtl/msk_reg_fifo.sv
// Masked storage FIFO: DEPTH entries of count d-share sharings with valid/ready and occupancy level.
// Define MSK_REFRESH_EN to add the rnd port and in-place share refresh of resident entries.
module msk_reg_fifo
    import msk_pkg::*;
#(
    parameter int d     = 2,
    parameter int count = 1,
    parameter int DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [count*d-1:0]                in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [count*d-1:0]                out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
`ifdef MSK_REFRESH_EN
    input  logic [DEPTH*count*(d-1)-1:0]      rnd,
`endif
    output logic [lvl_w(DEPTH)-1:0]           level
);

    localparam int W  = count * d;
    localparam int LW = lvl_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [LW-1:0]    r_level;
    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_we;
    logic [W-1:0]     w_q [DEPTH];

    // Handshake flags depend only on the registered level, never on out_ready.
    assign in_ready  = (r_level != LW'(DEPTH));
    assign out_valid = (r_level != '0);
    assign level     = r_level;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push)
                r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
            if (w_pop)
                r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
            if (w_push && !w_pop)
                r_level <= r_level + 1'b1;
            else if (!w_push && w_pop)
                r_level <= r_level - 1'b1;
        end
    end

    always_comb begin
        w_we = '0;
        for (int e = 0; e < DEPTH; e++)
            w_we[e] = w_push && (r_wr == PW'(e));
    end

`ifdef MSK_REFRESH_EN
    logic [DEPTH-1:0] w_occ;

    // An entry is resident when its distance from the read pointer is below the level.
    always_comb begin
        int off;
        w_occ = '0;
        for (int e = 0; e < DEPTH; e++) begin
            off = e - int'(r_rd);
            if (off < 0) off = off + DEPTH;
            w_occ[e] = (off < int'(r_level));
        end
    end
`endif

    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        msk_fifo_entry #(
            .d     (d),
            .count (count)
        ) u_entry (
            .clk     (clk),
            .rst     (rst),
            .i_we    (w_we[e]),
            .i_wdata (in_data),
`ifdef MSK_REFRESH_EN
            .i_ref_en(w_occ[e]),
            .i_rnd   (rnd[e*count*(d-1) +: count*(d-1)]),
`endif
            .o_q     (w_q[e])
        );
    end

    // Per-share read mux selected by the read pointer alone.
    assign out_data = w_q[r_rd];

endmodule

// File: tb/tb_msk_reg_fifo.sv
// Self-checking bench for msk_reg_fifo (d=2, count=1, DEPTH=3) against a queue-based reference model.
module tb_msk_reg_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] level;
`ifdef MSK_REFRESH_EN
    logic [2:0] rnd = '0;
`endif

    int checks = 0;
    int failures = 0;
    logic [1:0] mq[$];

    always #5 clk = ~clk;

    msk_reg_fifo #(.d(2), .count(1), .DEPTH(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef MSK_REFRESH_EN
        .rnd      (rnd),
`endif
        .level    (level)
    );

    // One clock edge with the reference model advanced from the same inputs.
    task automatic step();
        bit pu, po;
        @(posedge clk);
        pu = in_valid && (mq.size() < 3) && !rst;
        po = out_ready && (mq.size() > 0) && !rst;
        if (po) void'(mq.pop_front());
        if (pu) mq.push_back(in_data);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++;
        if (level !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 2'b00) begin
            failures++;
            $display("FAIL reset_state: level=%0d ov=%b ir=%b od=%b required 0 0 1 00", level, out_valid, in_ready, out_data);
        end
        rst = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = 2'($urandom_range(1, 3));
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (level !== 2'd2) begin
            failures++;
            $display("FAIL pre_reset_level: got %0d required 2", level);
        end
        #2 rst = 1'b1;
        #1;
        mq.delete();
        checks++;
        if (level !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 2'b00) begin
            failures++;
            $display("FAIL midstream_reset: level=%0d ov=%b ir=%b od=%b required 0 0 1 00", level, out_valid, in_ready, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        checks++;
        if (level !== 2'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL after_reset_empty: level=%0d ov=%b required 0 0", level, out_valid);
        end
    endtask

    task automatic test_fill();
        logic [1:0] vals [4];
        vals = '{2'b01, 2'b10, 2'b11, 2'b00};
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = vals[i];
            step();
            checks++;
            if (level !== 2'(mq.size()) || in_ready !== (mq.size() != 3) || out_data !== 2'b01) begin
                failures++;
                $display("FAIL fill_%0d: level=%0d ir=%b od=%b required %0d %b 01", i, level, in_ready, out_data, mq.size(), mq.size() != 3);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (level !== 2'd3 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL fill_full: level=%0d ir=%b required 3 0", level, in_ready);
        end
    endtask

    task automatic test_drain_wrap();
        logic [1:0] exp_o [5];
        exp_o = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_o[i]) begin
                failures++;
                $display("FAIL drain_%0d: ov=%b od=%b required 1 %b", i, out_valid, out_data, exp_o[i]);
            end
            step();
        end
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 3; i < 5; i++) begin
            in_data = exp_o[i];
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 3; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_o[i]) begin
                failures++;
                $display("FAIL wrap_%0d: ov=%b od=%b required 1 %b", i, out_valid, out_data, exp_o[i]);
            end
            step();
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || level !== 2'd0 || mq.size() != 0) begin
            failures++;
            $display("FAIL wrap_empty: ov=%b level=%0d required 0 0", out_valid, level);
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] prev;
        in_valid = 1'b1;
        out_ready = 1'b0;
        prev = 2'($urandom);
        in_data = prev;
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== prev) begin
                failures++;
                $display("FAIL simul_data_%0d: ov=%b od=%b required 1 %b", i, out_valid, out_data, prev);
            end
            in_data = 2'($urandom);
            prev = in_data;
            step();
            checks++;
            if (level !== 2'd1) begin
                failures++;
                $display("FAIL simul_level_%0d: got %0d required 1", i, level);
            end
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        logic [1:0] stored [3];
        in_valid = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stored[i] = 2'($urandom);
            in_data = stored[i];
            step();
        end
        checks++;
        if (level !== 2'd3 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL fullpop_full: level=%0d ir=%b required 3 0", level, in_ready);
        end
        in_data = ~stored[2];
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (level !== 2'd2) begin
            failures++;
            $display("FAIL fullpop_level: got %0d required 2", level);
        end
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== stored[i]) begin
                failures++;
                $display("FAIL fullpop_drain_%0d: ov=%b od=%b required 1 %b", i, out_valid, out_data, stored[i]);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || level !== 2'd0) begin
            failures++;
            $display("FAIL fullpop_empty: ov=%b level=%0d required 0 0 (extra entry stored)", out_valid, level);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'($urandom);
            out_ready = 1'($urandom);
            in_data = 2'($urandom);
            step();
            checks++;
            if (level !== 2'(mq.size()) || out_valid !== (mq.size() != 0) || in_ready !== (mq.size() != 3)) begin
                failures++;
                $display("FAIL rand_flags_%0d: level=%0d ov=%b ir=%b required %0d", i, level, out_valid, in_ready, mq.size());
            end
            if (mq.size() != 0) begin
                checks++;
                if (out_data !== mq[0]) begin
                    failures++;
                    $display("FAIL rand_data_%0d: od=%b required %b", i, out_data, mq[0]);
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        out_ready = 1'b0;
    endtask

`ifdef MSK_REFRESH_EN
    task automatic test_refresh();
        logic [1:0] exp_s;
        rnd = 3'b111;
        in_valid = 1'b1;
        out_ready = 1'b0;
        in_data = 2'b01;
        step();
        in_valid = 1'b0;
        exp_s = 2'b01;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_data !== exp_s || (out_data[0] ^ out_data[1]) !== 1'b1) begin
                failures++;
                $display("FAIL refresh_%0d: od=%b required %b", i, out_data, exp_s);
            end
            step();
            exp_s = exp_s ^ 2'b11;
        end
        rnd = '0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        mq.delete();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL refresh_drain: ov=%b required 0", out_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_drain_wrap();
        test_simultaneous();
        test_full_pop();
        test_random();
`ifdef MSK_REFRESH_EN
        test_refresh();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
